// File: rtl/demux1to2_stream.sv
// Registered 1-to-2 stream demultiplexer.
// Routes whole packets and keeps per-output beat counters.
module demux1to2_stream #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_sel,
    input  logic             s_last,
    output logic             m0_valid,
    input  logic             m0_ready,
    output logic [WIDTH-1:0] m0_data,
    output logic             m0_last,
    output logic             m1_valid,
    input  logic             m1_ready,
    output logic [WIDTH-1:0] m1_data,
    output logic             m1_last,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    typedef enum logic {
        IDLE,
        PKT
    } state_t;

    state_t state, state_nxt;
    logic   sel_q, sel_nxt;
    logic   eff_sel;
    logic   free0, free1;
    logic   acc;
    logic   load0, load1;
    logic   hs0, hs1;

    assign eff_sel = (state == PKT) ? sel_q : s_sel;
    assign free0   = !m0_valid || m0_ready;
    assign free1   = !m1_valid || m1_ready;
    assign s_ready = !rst && (eff_sel ? free1 : free0);
    assign acc     = s_valid && s_ready;
    assign load0   = acc && !eff_sel;
    assign load1   = acc && eff_sel;
    assign hs0     = m0_valid && m0_ready;
    assign hs1     = m1_valid && m1_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sel_q <= 1'b0;
        end else begin
            state <= state_nxt;
            sel_q <= sel_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel_q;
        unique case (state)
            IDLE: begin
                if (acc && !s_last) begin
                    state_nxt = PKT;
                    sel_nxt   = s_sel;
                end
            end
            PKT: begin
                if (acc && s_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A load wins over a drain so back-to-back beats leave no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            m0_valid <= 1'b0;
            m0_data  <= '0;
            m0_last  <= 1'b0;
        end else if (load0) begin
            m0_valid <= 1'b1;
            m0_data  <= s_data;
            m0_last  <= s_last;
        end else if (m0_ready) begin
            m0_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m1_valid <= 1'b0;
            m1_data  <= '0;
            m1_last  <= 1'b0;
        end else if (load1) begin
            m1_valid <= 1'b1;
            m1_data  <= s_data;
            m1_last  <= s_last;
        end else if (m1_ready) begin
            m1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (hs0 && (cnt0 != '1)) cnt0 <= cnt0 + 1'b1;
            if (hs1 && (cnt1 != '1)) cnt1 <= cnt1 + 1'b1;
        end
    end

endmodule
